// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types and default 640x480@60 constants for the raster generator and draw
// stages.
package vga_timing_pkg;

  typedef logic [10:0] coord_t;

  localparam int unsigned H_ACTIVE_DEF   = 640;
  localparam int unsigned H_FP_DEF       = 16;
  localparam int unsigned H_SYNC_DEF     = 96;
  localparam int unsigned H_BP_DEF       = 48;
  localparam int unsigned V_ACTIVE_DEF   = 480;
  localparam int unsigned V_FP_DEF       = 10;
  localparam int unsigned V_SYNC_DEF     = 2;
  localparam int unsigned V_BP_DEF       = 33;
  localparam int unsigned CLK_DIV_DEF    = 2;
  localparam int unsigned SYNC_DELAY_DEF = 2;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned HS_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned HS_END   = HS_START + H_SYNC_DEF;
  localparam int unsigned VS_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned VS_END   = VS_START + V_SYNC_DEF;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with synchronous flush to a per-bit reset value.
module sync_delay_line #(
  parameter int unsigned        WIDTH     = 1,
  parameter int unsigned        DEPTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign data_o = data_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else begin
        stage_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign data_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_pixel_timing.sv
// VGA raster timing: pixel divider, H/V counters, frame counter and delayed sync/blank.
module vga_pixel_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned SYNC_DELAY = SYNC_DELAY_DEF
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        pixelTick,
  output logic        displayActive,
  output logic        startOfFrame,
  output logic        hSyncN,
  output logic        vSyncN,
  output logic        blankN,
  output logic [15:0] frameCount
);

  localparam int unsigned HTotal = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam coord_t     XMax    = coord_t'(HTotal - 1);
  localparam coord_t     YMax    = coord_t'(VTotal - 1);
  localparam coord_t     HActive = coord_t'(H_ACTIVE);
  localparam coord_t     VActive = coord_t'(V_ACTIVE);
  localparam coord_t     HsStart = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t     HsEnd   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t     VsStart = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t     VsEnd   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [1:0] DivMax  = 2'(CLK_DIV - 1);

  logic [1:0]  div_q, div_d;
  coord_t      x_q, x_d;
  coord_t      y_q, y_d;
  logic [15:0] frame_q, frame_d;
  logic        sof_q, sof_d;
  // Set while in reset; the first edge after release presents (0,0) without advancing.
  logic        hold_q;

  logic tick, line_end, frame_end;

  assign tick      = (div_q == DivMax) && !hold_q;
  assign line_end  = tick && (x_q == XMax);
  assign frame_end = line_end && (y_q == YMax);

  always_comb begin
    div_d   = div_q;
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;
    sof_d   = 1'b0;
    if (hold_q) begin
      sof_d = 1'b1;
    end else if (tick) begin
      div_d = '0;
      if (line_end) begin
        x_d = '0;
        if (frame_end) begin
          y_d     = '0;
          frame_d = frame_q + 16'd1;
          sof_d   = 1'b1;
        end else begin
          y_d = y_q + 11'd1;
        end
      end else begin
        x_d = x_q + 11'd1;
      end
    end else begin
      div_d = div_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      sof_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      sof_q   <= sof_d;
      hold_q  <= 1'b0;
    end
  end

  logic       hs_raw, vs_raw, active;
  logic [2:0] sync_raw, sync_dly;

  assign hs_raw = (x_q >= HsStart) && (x_q < HsEnd);
  assign vs_raw = (y_q >= VsStart) && (y_q < VsEnd);
  assign active = (x_q < HActive) && (y_q < VActive);

  // Gating with hold_q keeps the pins inactive during reset even with a zero-depth delay.
  assign sync_raw = {~(hs_raw && !hold_q), ~(vs_raw && !hold_q), active && !hold_q};

  sync_delay_line #(
    .WIDTH    (3),
    .DEPTH    (SYNC_DELAY),
    .RESET_VAL(3'b110)
  ) u_sync_dly (
    .clk_i (clk),
    .rst_i (resetN),
    .data_i(sync_raw),
    .data_o(sync_dly)
  );

  assign pixelX        = x_q;
  assign pixelY        = y_q;
  assign pixelTick     = tick;
  assign displayActive = active;
  assign startOfFrame  = sof_q;
  assign hSyncN        = sync_dly[2];
  assign vSyncN        = sync_dly[1];
  assign blankN        = sync_dly[0];
  assign frameCount    = frame_q;

endmodule

// File: tb/tb_vga_pixel_timing.sv
// Directed bench: default timing, a shrunken-frame instance and a CLK_DIV=1/SYNC_DELAY=0 one.
module tb_vga_pixel_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_a = 1'b1, rst_b = 1'b1, rst_s = 1'b1;
  logic [10:0] x_a, y_a, x_b, y_b, x_s, y_s;
  logic        tick_a, act_a, sof_a, hs_a, vs_a, bl_a;
  logic        tick_b, act_b, sof_b, hs_b, vs_b, bl_b;
  logic        tick_s, act_s, sof_s, hs_s, vs_s, bl_s;
  logic [15:0] fc_a, fc_b, fc_s;

  vga_pixel_timing dut_a (
    .clk(clk), .resetN(rst_a), .pixelX(x_a), .pixelY(y_a), .pixelTick(tick_a),
    .displayActive(act_a), .startOfFrame(sof_a), .hSyncN(hs_a), .vSyncN(vs_a),
    .blankN(bl_a), .frameCount(fc_a)
  );

  // Default horizontal timing, 12-line frame, one clk per pixel, no sync delay.
  vga_pixel_timing #(
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .CLK_DIV(1), .SYNC_DELAY(0)
  ) dut_b (
    .clk(clk), .resetN(rst_b), .pixelX(x_b), .pixelY(y_b), .pixelTick(tick_b),
    .displayActive(act_b), .startOfFrame(sof_b), .hSyncN(hs_b), .vSyncN(vs_b),
    .blankN(bl_b), .frameCount(fc_b)
  );

  // 32x12 frame: hsync 20..27, vsync lines 8..9, 768 clks per frame.
  vga_pixel_timing #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .CLK_DIV(2), .SYNC_DELAY(2)
  ) dut_s (
    .clk(clk), .resetN(rst_s), .pixelX(x_s), .pixelY(y_s), .pixelTick(tick_s),
    .displayActive(act_s), .startOfFrame(sof_s), .hSyncN(hs_s), .vSyncN(vs_s),
    .blankN(bl_s), .frameCount(fc_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int exp_x [5] = '{0, 0, 1, 1, 2};
    int exp_t [5] = '{0, 1, 0, 1, 0};
    int exp_f [5] = '{1, 0, 0, 0, 0};
    int exp_b [5] = '{0, 0, 1, 1, 1};
    rst_a = 1'b1;
    step();
    step();
    checks++;
    if (x_a !== 11'd0 || y_a !== 11'd0) begin
      errors++;
      $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", x_a, y_a);
    end
    checks++;
    if ({tick_a, sof_a, fc_a} !== 18'd0) begin
      errors++;
      $display("FAIL reset_ctl: tick=%b sof=%b fc=%0d want 0,0,0", tick_a, sof_a, fc_a);
    end
    checks++;
    if ({hs_a, vs_a, bl_a} !== 3'b110) begin
      errors++;
      $display("FAIL reset_sync: hs,vs,bl=%b%b%b want 110", hs_a, vs_a, bl_a);
    end
    rst_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (x_a !== 11'(exp_x[i]) || tick_a !== 1'(exp_t[i]) || sof_a !== 1'(exp_f[i]) ||
          bl_a !== 1'(exp_b[i]) || y_a !== 11'd0) begin
        errors++;
        $display("FAIL release_c%0d: x=%0d y=%0d tick=%b sof=%b bl=%b want x=%0d y=0 %0d %0d %0d",
                 i + 1, x_a, y_a, tick_a, sof_a, bl_a, exp_x[i], exp_t[i], exp_f[i], exp_b[i]);
      end
      if (i == 0) begin
        checks++;
        if (act_a !== 1'b1) begin
          errors++;
          $display("FAIL release_active: got %b want 1", act_a);
        end
      end
    end
  endtask

  task automatic test_line();
    int n = 0;
    while (x_a !== 11'd656 && n < 3000) begin step(); n++; end
    checks++;
    if (x_a !== 11'd656) begin errors++; $display("FAIL hs_reach656: x=%0d want 656", x_a); end
    step();
    checks++;
    if (hs_a !== 1'b1) begin errors++; $display("FAIL hs_fall_early: hs=%b want 1", hs_a); end
    step();
    checks++;
    if (hs_a !== 1'b0) begin errors++; $display("FAIL hs_fall: hs=%b want 0", hs_a); end
    n = 0;
    while (x_a !== 11'd752 && n < 3000) begin step(); n++; end
    step();
    checks++;
    if (hs_a !== 1'b0) begin errors++; $display("FAIL hs_rise_early: hs=%b want 0", hs_a); end
    step();
    checks++;
    if (hs_a !== 1'b1) begin errors++; $display("FAIL hs_rise: hs=%b want 1", hs_a); end
    n = 0;
    while (x_a !== 11'd799 && n < 3000) begin step(); n++; end
    step();
    checks++;
    if (x_a !== 11'd799 || y_a !== 11'd0) begin
      errors++;
      $display("FAIL line_end_hold: got (%0d,%0d) want (799,0)", x_a, y_a);
    end
    step();
    checks++;
    if (x_a !== 11'd0 || y_a !== 11'd1) begin
      errors++;
      $display("FAIL line_wrap: got (%0d,%0d) want (0,1)", x_a, y_a);
    end
  endtask

  task automatic test_blank_line();
    int cnt = 0, first = 0, last = 0;
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    for (int i = 1; i <= 1300; i++) begin
      step();
      if (bl_a === 1'b1) begin
        cnt++;
        if (first == 0) first = i;
        last = i;
      end
    end
    checks++;
    if (cnt != 1280 || first != 3 || last != 1282) begin
      errors++;
      $display("FAIL blank_line: cnt=%0d first=%0d last=%0d want 1280 3 1282", cnt, first, last);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, bad = 0;
    int exp_b [6] = '{0, 0, 1, 1, 1, 1};
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    while (!(x_s === 11'd22 && y_s === 11'd8) && n < 2000) begin step(); n++; end
    checks++;
    if (hs_s !== 1'b0 || vs_s !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre_sync: hs=%b vs=%b want 0 0 at (%0d,%0d)", hs_s, vs_s, x_s, y_s);
    end
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    checks++;
    if (x_s !== 11'd0 || y_s !== 11'd0 || fc_s !== 16'd0 || sof_s !== 1'b0 ||
        {hs_s, vs_s, bl_s} !== 3'b110) begin
      errors++;
      $display("FAIL mid_reset: (%0d,%0d) fc=%0d sof=%b sync=%b%b%b want (0,0) 0 0 110",
               x_s, y_s, fc_s, sof_s, hs_s, vs_s, bl_s);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (hs_s !== 1'b1 || vs_s !== 1'b1 || bl_s !== 1'(exp_b[i]) || fc_s !== 16'd0) bad++;
      if (i == 0 && (sof_s !== 1'b1 || x_s !== 11'd0 || y_s !== 11'd0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_flush: %0d bad clks want 0", bad);
    end
  endtask

  task automatic test_frame();
    int vs_cnt = 0, vs_first = 0, vs_last = 0;
    int bl_cnt = 0, bl_runs = 0, bl_bad = 0, run = 0;
    int sof_cnt = 0, sof_bad = 0;
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    for (int i = 1; i <= 800; i++) begin
      step();
      if (vs_s === 1'b0) begin
        vs_cnt++;
        if (vs_first == 0) vs_first = i;
        vs_last = i;
      end
      if (i <= 768) begin
        if (bl_s === 1'b1) begin
          bl_cnt++;
          run++;
        end else if (run != 0) begin
          bl_runs++;
          if (run != 32) bl_bad++;
          run = 0;
        end
      end
      if (sof_s === 1'b1) begin
        sof_cnt++;
        if (i != 1 && i != 769) sof_bad++;
      end
      if (i == 768) begin
        checks++;
        if (x_s !== 11'd31 || y_s !== 11'd11 || fc_s !== 16'd0) begin
          errors++;
          $display("FAIL frame_last: (%0d,%0d) fc=%0d want (31,11) 0", x_s, y_s, fc_s);
        end
      end
      if (i == 769) begin
        checks++;
        if (x_s !== 11'd0 || y_s !== 11'd0 || fc_s !== 16'd1) begin
          errors++;
          $display("FAIL frame_wrap: (%0d,%0d) fc=%0d want (0,0) 1", x_s, y_s, fc_s);
        end
      end
    end
    checks++;
    if (vs_cnt != 128 || vs_first != 515 || vs_last != 642) begin
      errors++;
      $display("FAIL vsync_win: cnt=%0d first=%0d last=%0d want 128 515 642",
               vs_cnt, vs_first, vs_last);
    end
    checks++;
    if (bl_cnt != 192 || bl_runs != 6 || bl_bad != 0) begin
      errors++;
      $display("FAIL blank_frame: cnt=%0d runs=%0d badruns=%0d want 192 6 0",
               bl_cnt, bl_runs, bl_bad);
    end
    checks++;
    if (sof_cnt != 2 || sof_bad != 0) begin
      errors++;
      $display("FAIL sof_pulses: cnt=%0d misplaced=%0d want 2 0", sof_cnt, sof_bad);
    end
  endtask

  task automatic test_fast();
    int xe, ye;
    int bad_tick = 0, bad_xy = 0, bad_hs = 0, bad_vs = 0, bad_bl = 0, sof_cnt = 0;
    rst_b = 1'b1;
    step();
    step();
    checks++;
    if (tick_b !== 1'b0 || {hs_b, vs_b, bl_b} !== 3'b110) begin
      errors++;
      $display("FAIL fast_reset: tick=%b sync=%b%b%b want 0 110", tick_b, hs_b, vs_b, bl_b);
    end
    rst_b = 1'b0;
    for (int i = 1; i <= 9605; i++) begin
      step();
      xe = (i - 1) % 800;
      ye = ((i - 1) / 800) % 12;
      if (tick_b !== 1'b1) bad_tick++;
      if (x_b !== 11'(xe) || y_b !== 11'(ye)) bad_xy++;
      if (hs_b !== !(xe >= 656 && xe < 752)) bad_hs++;
      if (vs_b !== !(ye >= 8 && ye < 10)) bad_vs++;
      if (bl_b !== (xe < 640 && ye < 6)) bad_bl++;
      if (sof_b === 1'b1) sof_cnt++;
    end
    checks++;
    if (bad_tick != 0) begin errors++; $display("FAIL fast_tick: %0d low clks want 0", bad_tick); end
    checks++;
    if (bad_xy != 0) begin errors++; $display("FAIL fast_xy: %0d bad clks want 0", bad_xy); end
    checks++;
    if (bad_hs != 0) begin errors++; $display("FAIL fast_hsync: %0d bad clks want 0", bad_hs); end
    checks++;
    if (bad_vs != 0) begin errors++; $display("FAIL fast_vsync: %0d bad clks want 0", bad_vs); end
    checks++;
    if (bad_bl != 0) begin errors++; $display("FAIL fast_blank: %0d bad clks want 0", bad_bl); end
    checks++;
    if (fc_b !== 16'd1 || sof_cnt != 2) begin
      errors++;
      $display("FAIL fast_frame: fc=%0d sof=%0d want 1 2", fc_b, sof_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    step();
    test_reset();
    test_line();
    test_blank_line();
    test_reset_mid();
    test_frame();
    test_fast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
